// File: rtl/latch_sched_pkg.sv
// Shared types and constants for the latch bank write sequencer.
package latch_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_GATE,
    ST_HOLD
  } state_e;

  localparam int DEF_SLOTS       = 8;
  localparam int DEF_GATE_CYCLES = 2;

  // Address width for n slots, never below 1 so a single-slot bank still has a port.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/latch_bank_sched_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last winner.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  // last_b_q = 1 means B won last, so A is preferred on a tie.
  logic last_b_q;

  assign gnt_a_o = en_i & req_a_i & (~req_b_i | last_b_q);
  assign gnt_b_o = en_i & req_b_i & (~req_a_i | ~last_b_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else if (gnt_a_o) begin
      last_b_q <= 1'b0;
    end else if (gnt_b_o) begin
      last_b_q <= 1'b1;
    end
  end

endmodule

// File: rtl/latch_bank_sched.sv
// Arbitrates two nibble writers onto a bank of transparent latches with setup/gate/hold strobes.
// Optional shadow readback array is enabled by defining LATCH_SHADOW_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a request; lat_d holds its last value
// ST_SETUP | data driven onto lat_d, all gates closed
// ST_GATE  | selected slot gate low for GATE_CYCLES cycles
// ST_HOLD  | gates closed, data still driven, ack to the granted requester
module latch_bank_sched
  import latch_sched_pkg::*;
#(
  parameter int SLOTS       = DEF_SLOTS,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  localparam int AW         = clog2_min1(SLOTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic [AW-1:0]    a_addr,
  input  logic [3:0]       a_data,
  output logic             a_ack,
  input  logic             b_req,
  input  logic [AW-1:0]    b_addr,
  input  logic [3:0]       b_data,
  output logic             b_ack,
  output logic [3:0]       lat_d,
  output logic [SLOTS-1:0] lat_ng,
  output logic             busy,
  input  logic [AW-1:0]    rd_addr,
  output logic [3:0]       rd_data
);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             who_b_q;
  logic [AW-1:0]    addr_q;
  logic [3:0]       data_q;
  logic [3:0]       lat_d_q;
  logic [SLOTS-1:0] lat_ng_q;
  logic             a_ack_q;
  logic             b_ack_q;
  logic             busy_q;
  logic             gnt_a;
  logic             gnt_b;
  logic [SLOTS-1:0] slot_sel;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en_i    (state_q == ST_IDLE),
    .req_a_i (a_req),
    .req_b_i (b_req),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  // An out-of-range address decodes to no slot, so the sequence runs without a strobe.
  always_comb begin
    slot_sel = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (addr_q == AW'(i)) slot_sel[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      who_b_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      lat_d_q  <= '0;
      lat_ng_q <= '1;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_a || gnt_b) begin
            who_b_q <= gnt_b;
            addr_q  <= gnt_b ? b_addr : a_addr;
            data_q  <= gnt_b ? b_data : a_data;
            lat_d_q <= gnt_b ? b_data : a_data;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          lat_ng_q <= ~slot_sel;
          cnt_q    <= 4'(GATE_CYCLES - 1);
          state_q  <= ST_GATE;
        end
        ST_GATE: begin
          if (cnt_q == 4'd0) begin
            lat_ng_q <= '1;
            a_ack_q  <= ~who_b_q;
            b_ack_q  <= who_b_q;
            state_q  <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lat_d  = lat_d_q;
  assign lat_ng = lat_ng_q;
  assign a_ack  = a_ack_q;
  assign b_ack  = b_ack_q;
  assign busy   = busy_q;

`ifdef LATCH_SHADOW_EN
  logic [3:0] shadow_q [SLOTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) shadow_q[i] <= '0;
    end else if (state_q == ST_SETUP) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (slot_sel[i]) shadow_q[i] <= data_q;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (rd_addr == AW'(i)) rd_data = shadow_q[i];
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = 4'h0;
`endif

endmodule

// File: tb/tb_latch_bank_sched.sv
// Randomised bench for latch_bank_sched: two instances (8 and 6 slots) share one stimulus stream.
module tb_latch_bank_sched;

  localparam int G = 2;

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, b_req;
  logic [2:0] a_addr, b_addr, rd_addr;
  logic [3:0] a_data, b_data;

  logic       a_ack0, b_ack0, busy0, a_ack1, b_ack1, busy1;
  logic [3:0] lat_d0, lat_d1, rd_data0, rd_data1;
  logic [7:0] ng0;
  logic [5:0] ng1;

  always #5 clk = ~clk;

  latch_bank_sched #(.SLOTS(8), .GATE_CYCLES(G)) dut8 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack0),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack0),
    .lat_d(lat_d0), .lat_ng(ng0), .busy(busy0),
    .rd_addr(rd_addr), .rd_data(rd_data0)
  );

  latch_bank_sched #(.SLOTS(6), .GATE_CYCLES(G)) dut6 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack1),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack1),
    .lat_d(lat_d1), .lat_ng(ng1), .busy(busy1),
    .rd_addr(rd_addr), .rd_data(rd_data1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: a write is a timeline of offsets after its grant cycle:
  // 1 = data presented, 2..G+1 = gate low, G+2 = ack, then one idle cycle.
  int         m_t = -1;
  bit         m_who;
  bit         m_last = 1'b1;
  int         m_addr;
  logic [3:0] m_data, m_latd;
  logic [3:0] sh [8];

  wr_t qa[$], qb[$];
  int  cyc = 0;
  int  a_ack_cyc, b_ack_cyc;
  int  ack_order[$];
  logic [7:0] prev_ng0 = 8'hFF;
  logic [3:0] prev_latd0;

  task automatic mdl_update();
    if (reset) begin
      m_t = -1; m_last = 1'b1; m_latd = 4'h0;
      for (int i = 0; i < 8; i++) sh[i] = 4'h0;
    end else if (m_t < 0) begin
      if (a_req || b_req) begin
        m_who  = (a_req && b_req) ? !m_last : b_req;
        m_last = m_who;
        m_addr = m_who ? int'(b_addr) : int'(a_addr);
        m_data = m_who ? b_data : a_data;
        m_latd = m_data;
        m_t    = 1;
      end
    end else begin
      m_t++;
      if (m_t == 2) sh[m_addr] = m_data;
      if (m_t > G + 2) m_t = -1;
    end
  endtask

  function automatic logic [7:0] exp_ng(input int slots);
    if (m_t >= 2 && m_t <= G + 1 && m_addr < slots) return ~(8'd1 << m_addr);
    return 8'hFF;
  endfunction

  function automatic logic [3:0] exp_rd(input int slots);
`ifdef LATCH_SHADOW_EN
    if (int'(rd_addr) < slots) return sh[rd_addr];
`endif
    return 4'h0;
  endfunction

  task automatic step();
    bit pa, pb;
    wr_t w;
    pa = (m_t == G + 2) && !m_who;
    pb = (m_t == G + 2) && m_who;
    @(posedge clk);
    mdl_update();
    cyc++;
    #1;
    if (pa) a_req = 1'b0;
    if (pb) b_req = 1'b0;
    if (!a_req && qa.size() > 0) begin
      w = qa.pop_front(); a_req = 1'b1; a_addr = w.addr; a_data = w.data;
    end else if (!a_req) begin
      a_addr = 3'($urandom); a_data = 4'($urandom);
    end
    if (!b_req && qb.size() > 0) begin
      w = qb.pop_front(); b_req = 1'b1; b_addr = w.addr; b_data = w.data;
    end else if (!b_req) begin
      b_addr = 3'($urandom); b_data = 4'($urandom);
    end
    rd_addr = 3'($urandom);
    @(negedge clk);
    chk("busy", busy0, m_t >= 0);
    chk("lat_d", lat_d0, m_latd);
    chk("ng8", ng0, exp_ng(8));
    chk("ng6", {2'b11, ng1}, exp_ng(6));
    chk("a_ack", a_ack0, (m_t == G + 2) && !m_who);
    chk("b_ack", b_ack0, (m_t == G + 2) && m_who);
    chk("ack6", {a_ack1, b_ack1, busy1, lat_d1}, {a_ack0, b_ack0, busy0, lat_d0});
    chk("rd8", rd_data0, exp_rd(8));
    chk("rd6", rd_data1, exp_rd(6));
    chk("one_low", $countones(~ng0) <= 1, 1);
    if (ng0 != 8'hFF && prev_ng0 != 8'hFF) chk("latd_stable", lat_d0, prev_latd0);
    if (a_ack0) begin a_ack_cyc = cyc; ack_order.push_back(0); end
    if (b_ack0) begin b_ack_cyc = cyc; ack_order.push_back(1); end
    prev_ng0 = ng0;
    prev_latd0 = lat_d0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || a_req || b_req || m_t >= 0) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) chk("drain_timeout", n, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int start;
    reset = 1'b1; a_req = 0; b_req = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0; rd_addr = 0;
    repeat (3) step();
    reset = 1'b0;

    // single A write, slot 5, data A
    qa.push_back('{3'd5, 4'hA});
    drain(50);

    // contention from a fresh pointer
    do_reset();
    qa.push_back('{3'd1, 4'h3});
    qb.push_back('{3'd2, 4'hC});
    drain(50);
    chk("contend_order", b_ack_cyc - a_ack_cyc, G + 3);

    // fairness: continuous requests on both sides
    start = ack_order.size();
    for (int i = 0; i < 6; i++) begin
      qa.push_back('{3'($urandom), 4'($urandom)});
      qb.push_back('{3'($urandom), 4'($urandom)});
    end
    drain(200);
    chk("fair_count", ack_order.size() - start, 12);
    for (int i = start + 1; i < ack_order.size(); i++)
      chk("fair_alt", ack_order[i] != ack_order[i-1], 1);

    // reset while A is mid-gate; B arrives meanwhile
    qa.push_back('{3'd4, 4'h6});
    for (int i = 0; i < 50 && m_t != 2; i++) step();
    qb.push_back('{3'd0, 4'h1});
    step();
    do_reset();
    chk("rst_busy", busy0, 0);
    chk("rst_ng", ng0, 8'hFF);
    drain(50);

    // out-of-range addresses on the 6-slot instance
    qa.push_back('{3'd7, 4'h5});
    qb.push_back('{3'd6, 4'hE});
    drain(50);

    // shadow readback
    do_reset();
    qa.push_back('{3'd3, 4'h9});
    drain(50);
    rd_addr = 3'd3;
    #1;
`ifdef LATCH_SHADOW_EN
    chk("shadow_rd3", rd_data0, 4'h9);
`else
    chk("shadow_rd3", rd_data0, 4'h0);
`endif
    rd_addr = 3'd4;
    #1;
    chk("shadow_rd4", rd_data0, 4'h0);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (qa.size() == 0 && $urandom_range(0, 3) == 0)
        qa.push_back('{3'($urandom), 4'($urandom)});
      if (qb.size() == 0 && $urandom_range(0, 3) == 0)
        qb.push_back('{3'($urandom), 4'($urandom)});
      reset = ($urandom_range(0, 99) == 0);
      step();
      reset = 1'b0;
    end
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
